// File: rtl/spike_encode_scheduler_if.sv
// rtl/spike_encode_scheduler_if.sv - pixel memory, RNG and spike vector stream signals of the scheduler
interface spike_encode_scheduler_if #(
  parameter int NUM_INPUTS = 16,
  parameter int ADDR_W     = 4,
  parameter int STEP_W     = 4
);
  logic [ADDR_W-1:0]     pix_addr;
  logic [7:0]            pix_data;
  logic [7:0]            rng_freq;
  logic                  rng_shift;
  logic                  rng_bit;
  logic                  spk_valid;
  logic                  spk_ready;
  logic [NUM_INPUTS-1:0] spk_data;
  logic [STEP_W-1:0]     spk_step;

  modport master (
    output pix_addr, rng_freq, rng_shift, spk_valid, spk_data, spk_step,
    input  pix_data, rng_bit, spk_ready
  );

  modport slave (
    input  pix_addr, rng_freq, rng_shift, spk_valid, spk_data, spk_step,
    output pix_data, rng_bit, spk_ready
  );
endinterface

// File: rtl/spike_encode_scheduler.sv
// rtl/spike_encode_scheduler.sv - walks every pixel through the shared Poisson RNG once per timestep
module spike_encode_scheduler #(
  parameter int NUM_INPUTS = 16,
  parameter int ADDR_W     = 4,
  parameter int NUM_STEPS  = 8,
  parameter int STEP_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  spike_encode_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SAMPLE,
    S_OUTPUT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_INPUTS - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [NUM_INPUTS-1:0] data_q, data_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [7:0]            freq_q, freq_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      freq_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      freq_q  <= freq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    data_d  = data_q;
    addr_d  = addr_q;
    freq_d  = freq_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          step_d  = '0;
          data_d  = '0;
        end
      end
      S_FETCH: begin
        addr_d  = idx_q;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        freq_d  = bus.pix_data;
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        data_d[idx_q] = bus.rng_bit;
        if (idx_q == LAST_IDX) begin
          state_d = S_OUTPUT;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_OUTPUT: begin
        // Nothing advances until the vector is taken, so stalls never consume RNG shifts.
        if (bus.spk_ready) begin
          if (step_q == LAST_STEP) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + STEP_W'(1);
            idx_d   = '0;
            data_d  = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address is presented during FETCH itself so the registered memory returns data in LOAD.
  assign bus.pix_addr  = addr_d;
  assign bus.rng_freq  = freq_q;
  assign bus.rng_shift = (state_q == S_SAMPLE);
  assign bus.spk_valid = (state_q == S_OUTPUT);
  assign bus.spk_data  = data_q;
  assign bus.spk_step  = step_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_spike_encode_scheduler.sv
// tb/tb_spike_encode_scheduler.sv - directed and randomized checks of the spike encode scheduler
module tb_spike_encode_scheduler;
  localparam int NI = 16;
  localparam int AW = 4;
  localparam int NS = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  spike_encode_scheduler_if #(.NUM_INPUTS(NI), .ADDR_W(AW), .STEP_W(SW)) bus ();

  spike_encode_scheduler #(.NUM_INPUTS(NI), .ADDR_W(AW), .NUM_STEPS(NS), .STEP_W(SW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]    pix_mem [NI];
  logic [15:0]   lfsr;
  logic          lfsr_load = 1'b1;
  int            mode = 0;
  int            total = 0;
  int            bad = 0;
  logic [NI-1:0] vq [$];
  logic [SW-1:0] sq [$];
  logic [7:0]    fq [$];
  logic [AW-1:0] aq [$];
  int            shift_cnt = 0;
  int            done_cnt = 0;
  logic [NI-1:0] exp_v [NS];

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Stand-in RNG: 0 = always spike, 1 = rate LSB, 2 = LFSR threshold (rate 30 spikes only on l[4:0]==31)
  function automatic logic rng_model(input int m, input logic [7:0] f, input logic [15:0] l);
    case (m)
      0:       return 1'b1;
      1:       return f[0];
      default: return ({1'b0, f} + {4'b0, l[4:0]}) > 9'd60;
    endcase
  endfunction

  assign bus.rng_bit = rng_model(mode, bus.rng_freq, lfsr);

  always @(posedge clk) bus.pix_data <= pix_mem[bus.pix_addr];

  always @(posedge clk) begin
    if (lfsr_load) lfsr <= 16'hACE1;
    else if (bus.rng_shift) lfsr <= lfsr_next(lfsr);
  end

  always @(negedge clk) begin
    if (bus.spk_valid && bus.spk_ready) begin
      vq.push_back(bus.spk_data);
      sq.push_back(bus.spk_step);
    end
    if (bus.rng_shift) begin
      shift_cnt++;
      fq.push_back(bus.rng_freq);
      aq.push_back(bus.pix_addr);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 5000) begin
      tick();
      n++;
    end
    chk(tag, n < 5000, 1);
  endtask

  task automatic build_expected(input int m, input logic [15:0] seed);
    logic [15:0] l = seed;
    for (int s = 0; s < NS; s++) begin
      exp_v[s] = '0;
      for (int i = 0; i < NI; i++) begin
        exp_v[s][i] = rng_model(m, pix_mem[i], l);
        l = lfsr_next(l);
      end
    end
  endtask

  task automatic check_image(input string tag, input int v0);
    chk({tag, "_count"}, vq.size() - v0, NS);
    for (int s = 0; s < NS; s++) begin
      if (v0 + s < vq.size()) begin
        chk({tag, "_data"}, vq[v0 + s], exp_v[s]);
        chk({tag, "_step"}, sq[v0 + s], s);
      end
    end
  endtask

  task automatic run_image(input string tag);
    int v0 = vq.size();
    int sc0 = shift_cnt;
    pulse_start();
    wait_done({tag, "_done"});
    tick();
    check_image(tag, v0);
    chk({tag, "_shifts"}, shift_cnt - sc0, NI * NS);
  endtask

  initial begin
    int v0, v1, sc0, dc0, f0, n, errs;
    logic [NI-1:0] d_hold;
    logic [SW-1:0] s_hold;
    logic [AW-1:0] a_hold;
    int e_valid, e_data, e_step, e_addr, e_shift;

    bus.spk_ready = 1'b0;
    for (int i = 0; i < NI; i++) pix_mem[i] = 8'd0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus.spk_valid, 0);
    chk("rst_shift", bus.rng_shift, 0);
    chk("rst_addr", bus.pix_addr, 0);
    chk("rst_freq", bus.rng_freq, 0);
    chk("rst_data", bus.spk_data, 0);
    chk("rst_step", bus.spk_step, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    lfsr_load = 1'b0;
    tick();

    // all-ones RNG, free-flowing sink, latency from start
    mode = 0;
    bus.spk_ready = 1'b1;
    build_expected(0, 16'h0);
    v0 = vq.size(); sc0 = shift_cnt; dc0 = done_cnt;
    pulse_start();
    n = 0;
    while (!bus.spk_valid && n < 200) begin
      tick();
      n++;
    end
    chk("first_valid_cycles", n + 1, 49);
    wait_done("t1_done");
    tick();
    check_image("t1", v0);
    chk("t1_shifts", shift_cnt - sc0, 128);
    chk("t1_done_pulses", done_cnt - dc0, 1);
    chk("t1_idle_busy", busy, 0);

    // rate LSB as spike, pix[i]=i
    mode = 1;
    for (int i = 0; i < NI; i++) pix_mem[i] = 8'(i);
    build_expected(1, 16'h0);
    f0 = fq.size();
    run_image("t2");
    errs = 0;
    for (int k = 0; k < NS * NI; k++) begin
      if (fq[f0 + k] !== 8'(k % NI)) errs++;
      if (aq[f0 + k] !== AW'(k % NI)) errs++;
    end
    chk("t2_freq_addr_seq", errs, 0);
    chk("t2_vec0_const", vq[vq.size() - 1], 16'hAAAA);

    // random rates with a 20-cycle stall at step 2
    for (int i = 0; i < NI; i++) pix_mem[i] = 8'($urandom_range(0, 255));
    build_expected(1, 16'h0);
    bus.spk_ready = 1'b0;
    v0 = vq.size();
    pulse_start();
    for (int s = 0; s < NS; s++) begin
      n = 0;
      while (!bus.spk_valid && n < 1000) begin
        tick();
        n++;
      end
      chk("t3_valid_arrive", n < 1000, 1);
      if (s == 2) begin
        d_hold = bus.spk_data; s_hold = bus.spk_step; a_hold = bus.pix_addr; sc0 = shift_cnt;
        e_valid = 0; e_data = 0; e_step = 0; e_addr = 0; e_shift = 0;
        repeat (20) begin
          tick();
          if (bus.spk_valid !== 1'b1) e_valid++;
          if (bus.spk_data !== d_hold) e_data++;
          if (bus.spk_step !== s_hold) e_step++;
          if (bus.pix_addr !== a_hold) e_addr++;
          if (bus.rng_shift !== 1'b0) e_shift++;
        end
        chk("t3_stall_valid", e_valid, 0);
        chk("t3_stall_data", e_data, 0);
        chk("t3_stall_step", e_step, 0);
        chk("t3_stall_addr", e_addr, 0);
        chk("t3_stall_noshift", e_shift + (shift_cnt - sc0), 0);
      end
      bus.spk_ready = 1'b1;
      tick();
      bus.spk_ready = 1'b0;
    end
    wait_done("t3_done");
    tick();
    check_image("t3", v0);
    bus.spk_ready = 1'b1;

    // start while busy ignored; start held across DONE restarts
    mode = 0;
    build_expected(0, 16'h0);
    v0 = vq.size(); sc0 = shift_cnt;
    pulse_start();
    n = 0;
    while (vq.size() - v0 < 4 && n < 2000) begin
      tick();
      n++;
    end
    pulse_start();
    @(negedge clk);
    start = 1'b1;
    wait_done("t4_done_a");
    chk("t4_first_count", vq.size() - v0, NS);
    tick();
    chk("t4_idle_busy", busy, 0);
    tick();
    chk("t4_restart_busy", busy, 1);
    chk("t4_restart_step", bus.spk_step, 0);
    @(negedge clk);
    start = 1'b0;
    v1 = v0 + NS;
    wait_done("t4_done_b");
    tick();
    check_image("t4b", v1);
    chk("t4_shifts", shift_cnt - sc0, 2 * NI * NS);

    // reset at step 3, pixel 5 sample
    v0 = vq.size(); sc0 = shift_cnt;
    pulse_start();
    n = 0;
    while (!(bus.rng_shift && (shift_cnt - sc0) == 3 * NI + 5) && n < 2000) begin
      tick();
      n++;
    end
    chk("t5_reach", n < 2000, 1);
    chk("t5_step", bus.spk_step, 3);
    chk("t5_addr", bus.pix_addr, 5);
    rst = 1'b1;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_valid", bus.spk_valid, 0);
    chk("t5_shift", bus.rng_shift, 0);
    chk("t5_addr_rst", bus.pix_addr, 0);
    chk("t5_freq", bus.rng_freq, 0);
    chk("t5_data", bus.spk_data, 0);
    chk("t5_step_rst", bus.spk_step, 0);
    chk("t5_done", done, 0);
    rst = 1'b0;
    chk("t5_aborted_count", vq.size() - v0, 3);
    tick();
    run_image("t5_after");

    // LFSR-driven RNG against the sequential golden model
    mode = 2;
    for (int i = 0; i < NI; i++) pix_mem[i] = 8'd10;
    lfsr_load = 1'b1; tick(); lfsr_load = 1'b0;
    build_expected(2, 16'hACE1);
    run_image("t6_rate10");
    for (int i = 0; i < NI; i++) pix_mem[i] = 8'd30;
    lfsr_load = 1'b1; tick(); lfsr_load = 1'b0;
    build_expected(2, 16'hACE1);
    run_image("t6_rate30");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NI; i++) pix_mem[i] = 8'($urandom_range(0, 255));
      lfsr_load = 1'b1; tick(); lfsr_load = 1'b0;
      build_expected(2, 16'hACE1);
      run_image("t6_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spike_encode_scheduler.md
Name: spike_encode_scheduler

Overview:
Sequences the shared Poisson spike random number generator across NUM_INPUTS pixel rates for NUM_STEPS timesteps per image. For each pixel it fetches the 8-bit rate from pixel memory, presents it to the RNG, captures the spike bit and advances the LFSR once. It then emits one NUM_INPUTS-wide spike vector per timestep over a valid/ready handshake to the SNN input layer.

Parameters:
NUM_INPUTS, 16, number of input pixels/neurons encoded per timestep
ADDR_W, 4, pixel memory address width (2**ADDR_W >= NUM_INPUTS)
NUM_STEPS, 8, timesteps (spike vectors) generated per image
STEP_W, 4, width of timestep counter (2**STEP_W >= NUM_STEPS)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin encoding one image; sampled only in IDLE
pix_addr  output  ADDR_W  pixel memory read address
pix_data  input  8  pixel rate; valid one cycle after pix_addr (registered read)
rng_freq  output  8  registered rate driven to RNG rf_freq_buffer
rng_shift  output  1  one-cycle pulse to RNG lfsr_shift
rng_bit  input  1  RNG spike output (combinational from rng_freq and LFSR state)
spk_valid  output  1  spike vector valid
spk_ready  input  1  downstream accepts vector
spk_data  output  NUM_INPUTS  spike vector; bit i = pixel i
spk_step  output  STEP_W  timestep index of spk_data
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after last vector accepted

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; pix_addr=0, rng_freq=0, rng_shift=0, spk_valid=0, spk_data=0, spk_step=0, busy=0, done=0, idx=0. Reset mid-operation aborts at once; any pending vector is dropped and the next start restarts at step 0. LFSR state is not owned here.
- States: IDLE, FETCH, LOAD, SAMPLE, OUTPUT, DONE.
- IDLE: start=1 -> FETCH, with idx=0, spk_step=0, spk_data=0.
- FETCH: pix_addr=idx -> LOAD.
- LOAD: rng_freq <= pix_data -> SAMPLE.
- SAMPLE: spk_data[idx] <= rng_bit; rng_shift=1 for this cycle only. If idx==NUM_INPUTS-1 -> OUTPUT, else idx++ -> FETCH.
- Per-pixel cost is 3 cycles, so a full vector is ready 3*NUM_INPUTS cycles after entering FETCH at idx=0.
- OUTPUT: spk_valid=1. spk_data and spk_step are held stable until spk_valid&&spk_ready.
  - On handshake with spk_step==NUM_STEPS-1 -> DONE.
  - Otherwise spk_step++, idx=0, spk_data cleared -> FETCH.
  - spk_valid deasserts in the cycle after the handshake.
- DONE: done=1 for one cycle -> IDLE. busy drops in that IDLE cycle.
- rng_shift is asserted only in SAMPLE: exactly NUM_INPUTS*NUM_STEPS pulses per image. No shifts occur in OUTPUT stalls, so the spike sequence is independent of backpressure.
- start is ignored while busy. start held high through DONE restarts on the IDLE cycle.
- Counters never wrap: idx stops at NUM_INPUTS-1 and spk_step at NUM_STEPS-1.
- pix_addr holds its last value outside FETCH. rng_freq holds its last value outside LOAD.

Test Plan:
1. RNG stubbed rng_bit=1, spk_ready=1, start pulse -> 8 vectors, spk_data=16'hFFFF, spk_step 0..7; first spk_valid 49 cycles after start accepted; exactly 128 rng_shift pulses; one done pulse.
2. Stub rng_bit=rng_freq[0], pix[i]=i -> every vector spk_data=16'hAAAA; pix_addr sequence 0..15 repeats per step; rng_freq follows pix_data one cycle later.
3. spk_ready low for 20 cycles at step 2 -> spk_valid stays 1, spk_data/spk_step unchanged, rng_shift=0 and pix_addr frozen during stall; resumes with step 3 after release.
4. start pulsed at step 4 while busy -> ignored, total still 8 vectors; start held high across DONE -> second image starts immediately, spk_step restarts at 0.
5. rst asserted during step 3 SAMPLE at idx=5 -> next cycle all outputs at reset values, busy=0; new start yields full 8 vectors from step 0.
6. Real RNG+LFSR (seed 16'hACE1), all pixels 8'd10 -> all spk_data=0; all pixels 8'd30 -> spikes only where the 5 LFSR bits are all 1, matching the golden model.
